// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - fixed arithmetic-progression ROM with a valid/ready burst sequencer
// Accepts (addr, len) requests in IDLE and streams consecutive entries, wrapping modulo DEPTH.
module rom_burst_reader #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int INIT_BASE = 0,
   parameter int INIT_STEP = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_len_m1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              addr_err
);

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_t;

   // Compared one bit wider so DEPTH == 2^ADDR_W does not alias to zero.
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] rom [2**ADDR_W];

   for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_rom
      if (g < DEPTH) begin : g_entry
         assign rom[g] = DATA_W'(INIT_BASE + INIT_STEP * g);
      end else begin : g_pad
         assign rom[g] = '0;
      end
   end

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              busy_q, busy_d;
   logic              addr_err_q, addr_err_d;

   logic              addr_oob;
   logic [ADDR_W-1:0] next_addr;

   assign addr_oob  = {1'b0, req_addr} >= DEPTH_X;
   assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      addr_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (addr_oob) begin
                  addr_err_d = 1'b1;
               end else begin
                  addr_d      = req_addr;
                  cnt_d       = req_len_m1;
                  out_valid_d = 1'b1;
                  out_data_d  = rom[req_addr];
                  out_last_d  = (req_len_m1 == '0);
                  busy_d      = 1'b1;
                  state_d     = ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  // out_data deliberately keeps the final beat.
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  addr_d     = next_addr;
                  cnt_d      = cnt_q - ADDR_W'(1);
                  out_data_d = rom[next_addr];
                  out_last_d = (cnt_q == ADDR_W'(1));
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb/tb_rom_burst_reader.sv - directed self-checking bench for rom_burst_reader
// Three instances: defaults, DEPTH=10/STEP=3, and DATA_W=4/STEP=5.
module tb_rom_burst_reader;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic       rv0, rr0, ov0, ordy0, ol0, busy0, ae0;
   logic [3:0] ra0, rl0;
   logic [7:0] od0;

   logic       rv1, rr1, ov1, ordy1, ol1, busy1, ae1;
   logic [3:0] ra1, rl1;
   logic [7:0] od1;

   logic       rv2, rr2, ov2, ordy2, ol2, busy2, ae2;
   logic [3:0] ra2, rl2;
   logic [3:0] od2;

   rom_burst_reader u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_addr(ra0),
      .req_len_m1(rl0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0),
      .out_last(ol0), .busy(busy0), .addr_err(ae0)
   );

   rom_burst_reader #(.DATA_W(8), .DEPTH(10), .ADDR_W(4), .INIT_BASE(0), .INIT_STEP(3)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_addr(ra1),
      .req_len_m1(rl1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
      .out_last(ol1), .busy(busy1), .addr_err(ae1)
   );

   rom_burst_reader #(.DATA_W(4), .DEPTH(16), .ADDR_W(4), .INIT_BASE(0), .INIT_STEP(5)) u2 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(rr2), .req_addr(ra2),
      .req_len_m1(rl2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2),
      .out_last(ol2), .busy(busy2), .addr_err(ae2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk0(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic b);
      chk({tag, ".valid"}, ov0, v);
      chk({tag, ".data"}, od0, d);
      chk({tag, ".last"}, ol0, l);
      chk({tag, ".busy"}, busy0, b);
   endtask

   initial begin
      logic [7:0] wrap_exp [4];
      logic [7:0] u1_exp [4];
      wrap_exp = '{8'd28, 8'd30, 8'd0, 8'd2};
      u1_exp   = '{8'd24, 8'd27, 8'd0, 8'd3};

      rst_n = 1'b0;
      rv0 = 0; ra0 = 0; rl0 = 0; ordy0 = 0;
      rv1 = 0; ra1 = 0; rl1 = 0; ordy1 = 0;
      rv2 = 0; ra2 = 0; rl2 = 0; ordy2 = 0;
      tick();
      tick();
      chk0("reset", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("reset.addr_err", ae0, 1'b0);
      chk("reset.req_ready", rr0, 1'b1);
      rst_n = 1'b1;
      tick();

      // single beat
      rv0 = 1; ra0 = 4'd3; rl0 = 4'd0;
      tick();
      rv0 = 0;
      chk0("single.beat", 1'b1, 8'd6, 1'b1, 1'b1);
      chk("single.req_ready_busy", rr0, 1'b0);
      ordy0 = 1;
      tick();
      chk0("single.done", 1'b0, 8'd6, 1'b0, 1'b0);
      chk("single.req_ready_after", rr0, 1'b1);

      // wrap burst across DEPTH-1 -> 0
      rv0 = 1; ra0 = 4'd14; rl0 = 4'd3;
      tick();
      rv0 = 0;
      for (int i = 0; i < 4; i++) begin
         chk0($sformatf("wrap.beat%0d", i), 1'b1, wrap_exp[i], (i == 3), 1'b1);
         tick();
      end
      chk0("wrap.done", 1'b0, 8'd2, 1'b0, 1'b0);

      // backpressure: out_ready 1,0,0,1,1
      ordy0 = 0;
      rv0 = 1; ra0 = 4'd0; rl0 = 4'd2;
      tick();
      rv0 = 0;
      ordy0 = 1;
      chk0("bp.beat0", 1'b1, 8'd0, 1'b0, 1'b1);
      tick();
      ordy0 = 0;
      chk0("bp.beat1", 1'b1, 8'd2, 1'b0, 1'b1);
      tick();
      chk0("bp.stall1", 1'b1, 8'd2, 1'b0, 1'b1);
      tick();
      chk0("bp.stall2", 1'b1, 8'd2, 1'b0, 1'b1);
      ordy0 = 1;
      tick();
      chk0("bp.beat2", 1'b1, 8'd4, 1'b1, 1'b1);
      tick();
      chk0("bp.done", 1'b0, 8'd4, 1'b0, 1'b0);

      // request held through STREAM; inputs changed mid-burst are ignored
      rv0 = 1; ra0 = 4'd5; rl0 = 4'd0;
      tick();
      chk0("held.first", 1'b1, 8'd10, 1'b1, 1'b1);
      ra0 = 4'd7;
      tick();
      chk0("held.idle_gap", 1'b0, 8'd10, 1'b0, 1'b0);
      chk("held.req_ready", rr0, 1'b1);
      tick();
      rv0 = 0;
      chk0("held.second", 1'b1, 8'd14, 1'b1, 1'b1);
      tick();
      chk0("held.done", 1'b0, 8'd14, 1'b0, 1'b0);

      // maximum length burst from the last entry
      rv0 = 1; ra0 = 4'd15; rl0 = 4'd15;
      tick();
      rv0 = 0;
      for (int i = 0; i < 16; i++) begin
         chk0($sformatf("long.beat%0d", i), 1'b1, 8'((2 * ((15 + i) % 16)) % 256),
              (i == 15), 1'b1);
         tick();
      end
      chk0("long.done", 1'b0, 8'd28, 1'b0, 1'b0);

      // non-power-of-two depth
      ordy1 = 1;
      rv1 = 1; ra1 = 4'd8; rl1 = 4'd3;
      tick();
      rv1 = 0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("d10.beat%0d.data", i), od1, u1_exp[i]);
         chk($sformatf("d10.beat%0d.last", i), ol1, (i == 3));
         chk($sformatf("d10.beat%0d.valid", i), ov1, 1'b1);
         tick();
      end
      chk("d10.done.valid", ov1, 1'b0);
      chk("d10.done.busy", busy1, 1'b0);

      rv1 = 1; ra1 = 4'd12; rl1 = 4'd1;
      tick();
      rv1 = 0;
      chk("d10.err12.addr_err", ae1, 1'b1);
      chk("d10.err12.valid", ov1, 1'b0);
      chk("d10.err12.req_ready", rr1, 1'b1);
      tick();
      chk("d10.err12.pulse_end", ae1, 1'b0);
      chk("d10.err12.valid_after", ov1, 1'b0);

      rv1 = 1; ra1 = 4'd10; rl1 = 4'd0;
      tick();
      rv1 = 0;
      chk("d10.err10.addr_err", ae1, 1'b1);
      chk("d10.err10.valid", ov1, 1'b0);
      tick();
      chk("d10.err10.pulse_end", ae1, 1'b0);

      rv1 = 1; ra1 = 4'd9; rl1 = 4'd1;
      tick();
      rv1 = 0;
      chk("d10.a9.data", od1, 8'd27);
      chk("d10.a9.addr_err", ae1, 1'b0);
      tick();
      chk("d10.a9.wrap_data", od1, 8'd0);
      chk("d10.a9.wrap_last", ol1, 1'b1);
      tick();

      // truncation to DATA_W=4
      ordy2 = 1;
      rv2 = 1; ra2 = 4'd3; rl2 = 4'd1;
      tick();
      rv2 = 0;
      chk("trunc.beat0.data", od2, 4'd15);
      chk("trunc.beat0.last", ol2, 1'b0);
      tick();
      chk("trunc.beat1.data", od2, 4'd4);
      chk("trunc.beat1.last", ol2, 1'b1);
      tick();
      chk("trunc.done.valid", ov2, 1'b0);

      // reset mid-burst on the 2nd beat of 6
      rv0 = 1; ra0 = 4'd1; rl0 = 4'd5;
      tick();
      rv0 = 0;
      chk0("rst.beat0", 1'b1, 8'd2, 1'b0, 1'b1);
      tick();
      chk0("rst.beat1", 1'b1, 8'd4, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk0("rst.async", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("rst.async.req_ready", rr0, 1'b1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk0($sformatf("rst.after%0d", i), 1'b0, 8'd0, 1'b0, 1'b0);
         chk($sformatf("rst.after%0d.req_ready", i), rr0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Parametrised read-only lookup table with fixed arithmetic-progression contents.
- A burst sequencer streams consecutive entries out over a valid/ready interface.
- Next generation of the team's small fixed ROM: generic width and depth, contents set at elaboration rather than reloaded on reset, plus burst reads, backpressure and address-error reporting.
- Sits between a control FSM (request side) and a datapath consumer (stream side).

Parameters:
DATA_W, 8, width of each entry
DEPTH, 16, number of entries (any value >= 2; need not be a power of two)
ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH
INIT_BASE, 0, value of entry 0
INIT_STEP, 2, increment between consecutive entries

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  burst request present
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  first entry of the burst
req_len_m1  in  ADDR_W  burst length minus one (1..2^ADDR_W beats)
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  consumer accepts the beat
out_data  out  DATA_W  entry value
out_last  out  1  final beat of the burst
busy  out  1  burst in progress
addr_err  out  1  one-cycle pulse: request rejected

Behaviour:
- Contents: entry i = (INIT_BASE + INIT_STEP*i) mod 2^DATA_W, constant. Contents are not reset-dependent and have no write path.
- Reset (asynchronous assert, any time): state IDLE, out_valid=0, out_data=0, out_last=0, busy=0, addr_err=0, and internal address/count registers cleared. Any burst in flight is abandoned with no further beats.
- req_ready = (state==IDLE), combinational from state, so it reads 1 out of reset.
- States:
  - IDLE:
    - A request is accepted when req_valid && req_ready.
    - If req_addr >= DEPTH: reject. addr_err=1 for exactly the next cycle, no beats, stay IDLE.
    - Otherwise: latch addr=req_addr and cnt=req_len_m1, then go to STREAM.
    - On the same edge: out_valid<=1, out_data<=entry[req_addr], out_last<=(req_len_m1==0), busy<=1.
    - Latency: first beat is valid 1 cycle after acceptance.
  - STREAM:
    - Hold: while out_valid && !out_ready, out_data, out_last and out_valid stay stable.
    - Beat with out_last=1 on handshake: out_valid<=0, out_last<=0, busy<=0, go to IDLE. out_data keeps its last value.
    - Beat with out_last=0 on handshake: addr<=next, cnt<=cnt-1, out_data<=entry[next], out_last<=(cnt==1).
    - Throughput: 1 beat/cycle under continuous out_ready.
- Wrap-around: next = (addr==DEPTH-1) ? 0 : addr+1. Wrapping is modulo DEPTH, not 2^ADDR_W.
- Bursts longer than DEPTH revisit entries cyclically.
- Back-to-back bursts: a new request is only accepted in IDLE, so there is one idle cycle between bursts.
- A req_valid held during STREAM is neither accepted nor dropped; it is taken in the first IDLE cycle.
- Request inputs are sampled only on the accepting edge; later changes during the burst have no effect.
- Arithmetic: entry computation truncates to DATA_W bits. Addresses and counts are unsigned.

Test Plan:
- Reset then single beat (defaults): req_addr=3, len_m1=0 -> next cycle out_valid=1, out_data=6, out_last=1; handshake -> out_valid=0, req_ready=1.
- Wrap burst (defaults): req_addr=14, len_m1=3, out_ready=1 -> out_data 28,30,0,2 on consecutive cycles; out_last only on the 4th beat; busy deasserts after it.
- Backpressure: req_addr=0, len_m1=2, out_ready toggling 1,0,0,1,1 -> beats 0,2,4 each delivered once; out_data stable while stalled.
- Non-power-of-two DEPTH=10, STEP=3:
  - req_addr=8, len_m1=3 -> 24,27,0,3.
  - req_addr=12 -> addr_err pulse for 1 cycle, no out_valid, req_ready stays 1.
- Truncation, DATA_W=4, STEP=5: req_addr=3, len_m1=1 -> out_data 15 then 4 (20 mod 16).
- Reset mid-burst: assert rst_n=0 on the 2nd beat of a 6-beat burst -> out_valid, out_last, busy and out_data all read 0 immediately. After release: IDLE, req_ready=1, no residual beats.
